// File: rtl/mux_sw_alloc.sv
// rtl/mux_sw_alloc.sv - round-robin switch allocator with packet lock and credit gating for a 2:1 router mux
module mux_sw_alloc #(
    parameter int               TYPEW     = 2,
    parameter logic [TYPEW-1:0] TYPE_HEAD = 2'b01,
    parameter logic [TYPEW-1:0] TYPE_DATA = 2'b10,
    parameter logic [TYPEW-1:0] TYPE_TAIL = 2'b11,
    parameter int               CREDITS   = 4,
    parameter int               CNTW      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ivalid_0,
    input  logic [TYPEW-1:0] itype_0,
    input  logic             ivalid_1,
    input  logic [TYPEW-1:0] itype_1,
    input  logic             credit_in,
    output logic [1:0]       sel,
    output logic             iready_0,
    output logic             iready_1,
    output logic             ovalid_g,
    output logic [CNTW-1:0]  credits,
    output logic             busy,
    output logic             cred_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    localparam logic [CNTW-1:0] FULL = CNTW'(CREDITS);

    state_t          r_state;
    logic [1:0]      r_sel;
    logic            r_ptr;
    logic [CNTW-1:0] r_credits;
    logic            r_cred_err;

    logic             w_req0;
    logic             w_req1;
    logic             w_win;
    logic             w_cred_ok;
    logic             w_lock;
    logic             w_xfer0;
    logic             w_xfer1;
    logic             w_xfer;
    logic [TYPEW-1:0] w_gtype;

    assign w_req0    = ivalid_0 && (itype_0 == TYPE_HEAD);
    assign w_req1    = ivalid_1 && (itype_1 == TYPE_HEAD);
    assign w_win     = (w_req0 && w_req1) ? r_ptr : w_req1;
    assign w_cred_ok = (r_credits != '0);
    assign w_lock    = (r_state == S_LOCK);

    // No credit bypass: a returning credit only becomes usable next cycle.
    assign w_xfer0 = w_lock && r_sel[0] && ivalid_0 && w_cred_ok;
    assign w_xfer1 = w_lock && r_sel[1] && ivalid_1 && w_cred_ok;
    assign w_xfer  = w_xfer0 || w_xfer1;
    assign w_gtype = r_sel[1] ? itype_1 : itype_0;

    assign sel      = r_sel;
    assign iready_0 = w_xfer0;
    assign iready_1 = w_xfer1;
    assign ovalid_g = w_xfer;
    assign credits  = r_credits;
    assign busy     = w_lock;
    assign cred_err = r_cred_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= 2'b00;
            r_ptr      <= 1'b0;
            r_credits  <= FULL;
            r_cred_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ((w_req0 || w_req1) && w_cred_ok) begin
                        r_state <= S_LOCK;
                        r_sel   <= w_win ? 2'b10 : 2'b01;
                    end
                end
                S_LOCK: begin
                    if (w_xfer) begin
                        case (w_gtype)
                            TYPE_TAIL: begin
                                r_state <= S_IDLE;
                                r_sel   <= 2'b00;
                                r_ptr   <= ~r_sel[1];
                            end
                            TYPE_HEAD, TYPE_DATA: r_state <= S_LOCK;
                            default:              r_state <= S_LOCK;
                        endcase
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sel   <= 2'b00;
                end
            endcase

            case ({w_xfer, credit_in})
                2'b10: r_credits <= r_credits - 1'b1;
                2'b01: begin
                    if (r_credits == FULL) begin
                        r_cred_err <= 1'b1;
                    end else begin
                        r_credits <= r_credits + 1'b1;
                    end
                end
                default: r_credits <= r_credits;
            endcase
        end
    end

endmodule

// File: doc/mux_sw_alloc.md
Name: mux_sw_alloc

Overview:
- Switch allocator for the 2:1 router output mux; generates the mux `sel` and per-input ready signals.
- Arbitrates round-robin between head flits on input ports 0 and 1.
- Locks the grant from head to tail so packets never interleave.
- Gates every flit transfer on a downstream credit counter, so the mux output never overruns the next-hop buffer.

Parameters:
- TYPEW, 2, width of the flit type field (top bits of `idata_k`).
- TYPE_HEAD, 2'b01, head flit encoding.
- TYPE_DATA, 2'b10, body flit encoding.
- TYPE_TAIL, 2'b11, tail flit encoding. TYPE_NONE is 2'b00.
- CREDITS, 4, downstream buffer depth; reset value of the credit counter.
- CNTW, 3, credit counter width; must hold CREDITS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ivalid_0  in  1  input 0 flit valid (same signal that feeds the mux).
- itype_0  in  TYPEW  input 0 flit type (`idata_0` top TYPEW bits).
- ivalid_1  in  1  input 1 flit valid.
- itype_1  in  TYPEW  input 1 flit type.
- credit_in  in  1  one-cycle pulse: downstream freed one buffer slot.
- sel  out  2  one-hot mux select; 2'b01 = port 0, 2'b10 = port 1, 2'b00 = none.
- iready_0  out  1  input 0 flit accepted this cycle.
- iready_1  out  1  input 1 flit accepted this cycle.
- ovalid_g  out  1  a flit is transferred through the mux this cycle.
- credits  out  CNTW  current credit count.
- busy  out  1  allocator is in LOCK.
- cred_err  out  1  sticky: credit_in arrived while the counter was at CREDITS.

Behaviour:
- Reset (asynchronous, any time including mid-packet) forces:
  - state = IDLE, sel = 2'b00, ptr = 0 (port 0 favoured);
  - credits = CREDITS, cred_err = 0, busy = 0.
  - iready_0, iready_1 and ovalid_g read 0 combinationally.
- Requests: req_k = ivalid_k && itype_k == TYPE_HEAD. A valid non-head flit in IDLE is not a request and is never accepted.
- State IDLE:
  - sel = 00; iready_k = 0.
  - If any req_k and credits > 0: grant the request winner. If both request, the winner is the port equal to ptr. Next state LOCK; sel registered one-hot to the winner at the next edge.
  - If credits == 0: stay in IDLE, no grant.
- State LOCK (granted port g):
  - iready_g = ivalid_g && credits > 0. The other port's iready is 0.
  - ovalid_g = iready_g.
  - A transfer with itype_g == TYPE_TAIL returns to IDLE at the next edge: sel -> 00, ptr -> the other port (1-g).
  - All other valid flits transfer and stay in LOCK. A valid TYPE_NONE flit is transferred and ignored for state purposes.
  - ivalid_g = 0 is a bubble: hold LOCK and sel.
- Latency: head arrives in cycle t (IDLE); sel is valid and the head transfers in cycle t+1 when credits permit. One idle cycle between back-to-back packets (tail at t, next head granted at t+1, transferred at t+2).
- Credit counter, per cycle:
  - transfer only: credits - 1.
  - credit_in only: credits + 1, saturating at CREDITS. credit_in at CREDITS sets cred_err and leaves the count unchanged.
  - both: unchanged.
  - There is no bypass: credits == 0 blocks the transfer even if credit_in is high that cycle.
- Simultaneous events:
  - Tail transfer and a head request on the other port in the same cycle: the head is not granted that cycle; it wins on the following cycle in IDLE (ptr already updated).
  - Requests arriving during LOCK are ignored until IDLE.

Test Plan:
- Reset, then head on port 1 at cycle 3, 20 data flits, then tail, credit_in asserted every cycle from cycle 4 → sel = 2'b10 from cycle 4; 22 iready_1 pulses; sel = 00 the cycle after the tail; credits never drop below 3.
- Heads on both ports at cycle 3 after reset → port 0 served first (sel = 01). After its tail, port 1 is granted next (sel = 10); ptr then = 0.
- No credit_in, 6-flit packet on port 0, CREDITS = 4 → 4 transfers, then iready_0 = 0 with credits = 0. A credit_in pulse resumes exactly one flit the following cycle.
- credit_in pulses while credits = 4 → cred_err = 1 and stays 1; credits stays 4 until reset.
- Assert rst asynchronously mid-packet (credits = 1, LOCK on port 1) → sel = 00, busy = 0, credits = 4, cred_err = 0 immediately. After rst falls, data flits without a head are ignored.
- Port 0 valid data flit (TYPE_DATA) in IDLE with no head → no grant, iready_0 = 0, state stays IDLE.
